// File: rtl/mem_march_tester.sv
// Register-array memory with a manual read/write port and a March C- self-test engine.
// Define MEM_MARCH_CHECKERBOARD_EN to add a second March C- pass over a checkerboard background.
module mem_march_tester #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  input  logic                 fault_en,
  input  logic [ADDR_BITS-1:0] fault_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [2:0]           fail_elem
);

  localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef MEM_MARCH_CHECKERBOARD_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             elem_q, elem_d;
  logic [ADDR_BITS-1:0]   baddr_q, baddr_d;
  logic                   phase_q, phase_d;
  logic                   pass2_q, pass2_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [7:0]             err_q, err_d;
  logic [ADDR_BITS-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]             fail_elem_q, fail_elem_d;
  logic [DATA_BITS-1:0]   rdata_q;

  logic [DATA_BITS-1:0]   mem_q [DEPTH];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr, mem_raddr;
  logic [DATA_BITS-1:0]   mem_wdata, mem_wdata_f;

  logic [DATA_BITS-1:0]   bg, exp_data, wr_val;
  logic [2:0]             elem_nx;
  logic                   elem_down, last_addr, step, mismatch;

`ifdef MEM_MARCH_CHECKERBOARD_EN
  assign bg = pass2_q ? ({(DATA_BITS/2){2'b01}} ^ {DATA_BITS{baddr_q[0]}}) : '0;
`else
  assign bg = '0;
`endif

  // Elements 2 and 4 read "1"; elements 1 and 3 write "1"; all else is the background.
  assign exp_data  = (elem_q == 3'd2 || elem_q == 3'd4) ? ~bg : bg;
  assign wr_val    = (elem_q == 3'd1 || elem_q == 3'd3) ? ~bg : bg;
  assign elem_down = (elem_q == 3'd3 || elem_q == 3'd4);
  assign last_addr = elem_down ? (baddr_q == '0) : (baddr_q == '1);
  assign elem_nx   = elem_q + 3'd1;

  assign busy      = (state_q == S_RUN);
  assign mem_raddr = busy ? baddr_q : addr;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    baddr_d     = baddr_q;
    phase_d     = phase_q;
    pass2_d     = pass2_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = wdata;
    step        = 1'b0;
    mismatch    = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we = we;
        if (start) begin
          state_d     = S_RUN;
          elem_d      = '0;
          baddr_d     = '0;
          phase_d     = 1'b0;
          pass2_d     = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      S_RUN: begin
        mem_waddr = baddr_q;
        mem_wdata = wr_val;
        if (elem_q == 3'd0) begin
          mem_we = 1'b1;
          step   = 1'b1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          mem_we   = (elem_q != 3'd5);
          mismatch = (rdata_q != exp_data);
          step     = 1'b1;
        end
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == 8'd0) begin
            fail_addr_d = baddr_q;
            fail_elem_d = elem_q;
          end
        end
        if (step) begin
          if (!last_addr) begin
            baddr_d = elem_down ? baddr_q - 1'b1 : baddr_q + 1'b1;
          end else if (elem_q != 3'd5) begin
            elem_d  = elem_nx;
            baddr_d = (elem_nx == 3'd3 || elem_nx == 3'd4) ? '1 : '0;
          end else if (CB_EN && !pass2_q) begin
            pass2_d = 1'b1;
            elem_d  = '0;
            baddr_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pass_d  = (err_d == 8'd0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wdata_f = mem_wdata;
    if (fault_en && mem_waddr == fault_addr) mem_wdata_f[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      baddr_q     <= '0;
      phase_q     <= 1'b0;
      pass2_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      baddr_q     <= baddr_d;
      phase_q     <= phase_d;
      pass2_q     <= pass2_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      rdata_q     <= mem_q[mem_raddr];
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule
